// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
//
// Unsigned shift-and-add multiplier controller. It has no adder or shifter of
// its own. It borrows a neighbouring 64-bit ALU by driving that ALU's operand
// and opcode inputs, and it captures the ALU's combinational result.
//
// One multiplication per accepted start pulse:
//   ITER : decide what to do next (terminate, add, or only shift)
//   ADD  : acc    <= acc + mcand            (ALU op 000)
//   SHL  : mcand  <= mcand << 1             (ALU op 100)
//   SHR  : mplier <= mplier >> 1, count++   (ALU op 101)
//   DONE : product <= acc, one-cycle done strobe
//
// The loop stops as soon as the remaining multiplier bits are all zero. Small
// multipliers therefore finish early. The latency is 2 + 3*k + popcount(op_b)
// cycles, where k is the index of the highest set bit of op_b plus one.
//
// Parameters
//   WIDTH        operand width, 1..32 (product always fits in 64 bits)
//
// Ports
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   start        request, sampled only while idle
//   op_a         multiplicand, latched on accepted start
//   op_b         multiplier, latched on accepted start
//   busy         high in every state except IDLE
//   done         one-cycle completion strobe (DONE state)
//   product      last completed product, held until the next completion
//   alu_in_A     ALU operand A
//   alu_in_B     ALU operand B
//   alu_control  ALU opcode
//   alu_out      ALU result, combinational from the three ALU inputs
// -----------------------------------------------------------------------------
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [63:0]      product,
  output logic [63:0]      alu_in_A,
  output logic [63:0]      alu_in_B,
  output logic [2:0]       alu_control,
  input  logic [63:0]      alu_out
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SHL = 3'b100;
  localparam logic [2:0] ALU_SHR = 3'b101;

  localparam logic [5:0] CNT_MAX = 6'(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ITER,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [63:0]      acc_q, acc_d;
  logic [63:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [5:0]       count_q, count_d;
  logic [63:0]      product_q, product_d;

  // Zero-extended view of the remaining multiplier bits. The ALU's right
  // shift then behaves logically, and zeros fill in from the top.
  logic [63:0]      mplier_ext;

  assign mplier_ext = {{(64-WIDTH){1'b0}}, mplier_q};

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, register updates and ALU drive
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    count_d     = count_q;
    product_d   = product_q;
    alu_in_A    = '0;
    alu_in_B    = '0;
    alu_control = ALU_ADD;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = {{(64-WIDTH){1'b0}}, op_a};
          mplier_d = op_b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = S_ITER;
        end
      end

      S_ITER: begin
        // The count guard is a safety net. With WIDTH multiplier bits,
        // mplier is already zero by the time count reaches WIDTH.
        if ((mplier_q == '0) || (count_q == CNT_MAX)) begin
          state_d = S_DONE;
        end else if (mplier_q[0]) begin
          state_d = S_ADD;
        end else begin
          state_d = S_SHL;
        end
      end

      S_ADD: begin
        alu_in_A    = acc_q;
        alu_in_B    = mcand_q;
        alu_control = ALU_ADD;
        acc_d       = alu_out;
        state_d     = S_SHL;
      end

      S_SHL: begin
        alu_in_A    = mcand_q;
        alu_control = ALU_SHL;
        mcand_d     = alu_out;
        state_d     = S_SHR;
      end

      S_SHR: begin
        alu_in_A    = mplier_ext;
        alu_control = ALU_SHR;
        mplier_d    = alu_out[WIDTH-1:0];
        count_d     = count_q + 6'd1;
        state_d     = S_ITER;
      end

      S_DONE: begin
        product_d = acc_q;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done;
  logic [63:0] product, alu_in_A, alu_in_B, alu_out;
  logic [2:0]  alu_control;

  logic        start8 = 1'b0;
  logic [7:0]  op_a8 = '0;
  logic [7:0]  op_b8 = '0;
  logic        busy8, done8;
  logic [63:0] product8, alu_in_A8, alu_in_B8, alu_out8;
  logic [2:0]  alu_control8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Reference model of the shared ALU: add, shift left by one, shift right by one.
  function automatic logic [63:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [2:0] c);
    case (c)
      3'b000:  return a + b;
      3'b100:  return a << 1;
      3'b101:  return a >> 1;
      default: return 64'h0;
    endcase
  endfunction

  assign alu_out  = alu_model(alu_in_A, alu_in_B, alu_control);
  assign alu_out8 = alu_model(alu_in_A8, alu_in_B8, alu_control8);

  alu_mul_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product),
    .alu_in_A(alu_in_A), .alu_in_B(alu_in_B), .alu_control(alu_control),
    .alu_out(alu_out)
  );

  alu_mul_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op_a(op_a8), .op_b(op_b8),
    .busy(busy8), .done(done8), .product(product8),
    .alu_in_A(alu_in_A8), .alu_in_B(alu_in_B8), .alu_control(alu_control8),
    .alu_out(alu_out8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic chks(input string name, input string act, input string exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
    end
  endtask

  // Issues one multiplication on the 32-bit DUT and records a per-cycle trace:
  // i=idle, I=ITER (busy, no ALU use), A=ADD, L=SHL, R=SHR, D=DONE, ?=other.
  // Entered and left at #1 after a rising edge. On return the bench is in the
  // DONE cycle, or in cycle stop_at if stop_at > 0.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int p1, input int p2, input int stop_at,
                        input bit done_pulse,
                        output int dcyc, output int adds, output string tr);
    byte ch;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tr    = "";
    adds  = 0;
    dcyc  = -1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (!busy)                                ch = "i";
      else if (done)                            ch = "D";
      else if (alu_control == 3'b100)           ch = "L";
      else if (alu_control == 3'b101)           ch = "R";
      else if (alu_control != 3'b000)           ch = "?";
      else if (alu_in_A != 0 || alu_in_B != 0)  ch = "A";
      else                                      ch = "I";
      tr = $sformatf("%s%c", tr, ch);
      if (ch == "A") adds++;
      if (done) begin
        dcyc = cyc;
        if (done_pulse) begin
          start = 1'b1;
          op_a  = 32'h1;
          op_b  = 32'h1;
        end
        break;
      end
      if (cyc == stop_at) break;
      start = (cyc == p1) || (cyc == p2);
      if (start) begin
        op_a = 32'h2;
        op_b = 32'h3;
      end
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    int          lat;
    int          adds;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int    d, ad, shr;
    string tr;
    bit    seen_done, seen_busy;

    vecs[0] = '{32'h3,        32'h5,        64'hF,                 13,  2};
    vecs[1] = '{32'h12345678, 32'h0,        64'h0,                 2,   0};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001,  130, 32};
    vecs[3] = '{32'h6,        32'h7,        64'd42,                14,  3};
    vecs[4] = '{32'h1,        32'h1,        64'h1,                 6,   1};
    vecs[5] = '{32'h80000000, 32'h2,        64'h100000000,         9,   1};
    vecs[6] = '{32'hFFFFFFFF, 32'h80000000, 64'h7FFFFFFF80000000,  99,  1};
    vecs[7] = '{32'hDEADBEEF, 32'h10,       64'hDEADBEEF0,         18,  1};
    vecs[8] = '{32'hFFFF,     32'hFFFF,     64'hFFFE0001,          66,  16};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",    64'(busy), 64'h0);
    chk("rst_done",    64'(done), 64'h0);
    chk("rst_product", product, 64'h0);
    chk("rst_alu_A",   alu_in_A, 64'h0);
    chk("rst_alu_B",   alu_in_B, 64'h0);
    chk("rst_alu_ctl", 64'(alu_control), 64'h0);
    chk("rst_busy8",   64'(busy8), 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 3 x 5: exact state order
    run_op(32'h3, 32'h5, 0, 0, 0, 1'b0, d, ad, tr);
    chks("trace_3x5", tr, "IALRILRIALRID");
    chk("lat_3x5", 64'(d), 64'd13);
    @(posedge clk); #1;
    chk("prod_3x5", product, 64'hF);
    chk("idle_busy_3x5", 64'(busy), 64'h0);
    chk("idle_done_3x5", 64'(done), 64'h0);

    // op_b = 0: no ALU activity; start during DONE is ignored
    run_op(32'h12345678, 32'h0, 0, 0, 0, 1'b1, d, ad, tr);
    chks("trace_b0", tr, "ID");
    chk("lat_b0", 64'(d), 64'd2);
    @(posedge clk); #1;
    start = 1'b0;
    chk("prod_b0", product, 64'h0);
    chk("idle_busy_b0", 64'(busy), 64'h0);
    @(posedge clk); #1;
    chk("done_start_ignored", 64'(busy), 64'h0);

    // Table of directed vectors
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, 0, 0, 0, 1'b0, d, ad, tr);
      chk($sformatf("lat_v%0d", i), 64'(d), 64'(vecs[i].lat));
      chk($sformatf("adds_v%0d", i), 64'(ad), 64'(vecs[i].adds));
      @(posedge clk); #1;
      chk($sformatf("prod_v%0d", i), product, vecs[i].prod);
      chk($sformatf("idle_v%0d", i), 64'(busy), 64'h0);
    end

    // Start pulses mid-run are ignored; start in the first IDLE cycle is taken
    run_op(32'h7, 32'h9, 4, 13, 0, 1'b0, d, ad, tr);
    chk("lat_7x9", 64'(d), 64'd16);
    @(posedge clk); #1;
    chk("prod_7x9", product, 64'd63);
    run_op(32'h5, 32'h3, 0, 0, 0, 1'b0, d, ad, tr);
    chk("lat_b2b", 64'(d), 64'd10);
    @(posedge clk); #1;
    chk("prod_b2b", product, 64'd15);

    // Reset in the middle of a run, with start high in the same cycle
    run_op(32'hFFFF, 32'hFFFF, 0, 0, 20, 1'b0, d, ad, tr);
    chk("pre_rst_busy", 64'(busy), 64'h1);
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy",    64'(busy), 64'h0);
    chk("mid_rst_done",    64'(done), 64'h0);
    chk("mid_rst_product", product, 64'h0);
    rst_n = 1'b1;
    start = 1'b0;
    seen_done = 1'b0;
    seen_busy = 1'b0;
    for (int c = 0; c < 150; c++) begin
      seen_done |= done;
      seen_busy |= busy;
      @(posedge clk); #1;
    end
    chk("no_done_after_rst", 64'(seen_done), 64'h0);
    chk("no_busy_after_rst", 64'(seen_busy), 64'h0);
    run_op(32'h6, 32'h7, 0, 0, 0, 1'b0, d, ad, tr);
    chk("lat_6x7_post_rst", 64'(d), 64'd14);
    @(posedge clk); #1;
    chk("prod_6x7_post_rst", product, 64'd42);

    // WIDTH = 8 instance: 0xFF x 0x80
    op_a8  = 8'hFF;
    op_b8  = 8'h80;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    d   = -1;
    shr = 0;
    for (int c = 1; c <= 100; c++) begin
      if (busy8 && alu_control8 == 3'b101) shr++;
      if (done8) begin
        d = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk("lat_w8", 64'(d), 64'd27);
    chk("shr_w8", 64'(shr), 64'd8);
    @(posedge clk); #1;
    chk("prod_w8", product8, 64'h7F80);
    chk("idle_w8", 64'(busy8), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle unsigned multiplier controller that sequences the shared 64-bit ALU through shift-and-add.
- Sits beside one ALU instance and drives its operand and control inputs. The ALU operations used are add (000), shift left (100) and shift right (101). It reads back the 64-bit result.
- Accepts one operand pair per start pulse and returns a 64-bit product with a one-cycle done strobe.

Parameters:
- WIDTH, 32, operand width in bits; legal range 1..32, so the product always fits in 64 bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- start  input  1  request; sampled only in IDLE.
- op_a  input  WIDTH  multiplicand; latched on accepted start.
- op_b  input  WIDTH  multiplier; latched on accepted start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse, high during the DONE state.
- product  output  64  last completed product; held until the next completion.
- alu_in_A  output  64  ALU operand A.
- alu_in_B  output  64  ALU operand B.
- alu_control  output  3  ALU opcode.
- alu_out  input  64  ALU result; combinational from alu_in_A, alu_in_B and alu_control in the same cycle.

Behaviour:
- Internal registers:
  - acc[63:0]: accumulator.
  - mcand[63:0]: shifted multiplicand.
  - mplier[WIDTH-1:0]: remaining multiplier bits.
  - count[5:0]: iterations done.
  - state: IDLE, ITER, ADD, SHL, SHR, DONE.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; busy=0, done=0, product=0; acc, mcand, mplier and count all 0.
  - Reset overrides every other event, including start in the same cycle and an operation in progress. Any partial result is discarded.
- IDLE:
  - ALU outputs are 0, 0, 000.
  - On start=1: mcand<={zeros,op_a}, mplier<=op_b, acc<=0, count<=0, then go to ITER.
- ITER (no ALU use; outputs 0, 0, 000):
  - If mplier==0 or count==WIDTH, go to DONE (early termination).
  - Else if mplier[0]==1, go to ADD.
  - Else go to SHL.
- ADD: alu_in_A=acc, alu_in_B=mcand, alu_control=000; acc<=alu_out; go to SHL.
- SHL: alu_in_A=mcand, alu_in_B=0, alu_control=100; mcand<=alu_out; go to SHR.
- SHR: alu_in_A={zeros,mplier}, alu_in_B=0, alu_control=101; mplier<=alu_out[WIDTH-1:0]; count<=count+1; go to ITER.
- DONE: product<=acc (visible from the next cycle); done=1; busy=1; go to IDLE.
- Handshake:
  - start is ignored whenever state!=IDLE, including the DONE cycle.
  - A new start is accepted in the first IDLE cycle after DONE, so the back-to-back issue interval is latency+1 cycles.
- Latency (from the start-sampling edge to the DONE cycle):
  - Formula: 2 + 3*k + p cycles, where k = bit position of the highest set bit of op_b + 1, and p = popcount(op_b).
  - op_b=0: DONE on cycle 2.
  - op_b=all ones with WIDTH=32: 130 cycles (the maximum).
- Arithmetic:
  - Unsigned only.
  - No overflow is possible: mcand is shifted at most WIDTH-1 times before its last use and acc stays below 2^(2*WIDTH). ALU carry-out is not needed.
  - Shift right on the ALU is logical for zero-extended mplier.
- ALU compare outputs (greater, lesser, equal) are not used.
- Outputs alu_* are combinational from state and registers. They must be stable within each state cycle.

Test Plan:
- Reset then op_a=3, op_b=5, start at cycle 0:
  - State order ITER,ADD,SHL,SHR,ITER,SHL,SHR,ITER,ADD,SHL,SHR,ITER,DONE.
  - done=1 at cycle 13, then product=0x000000000000000F.
  - busy high on cycles 1..13.
- op_a=0x12345678, op_b=0: done at cycle 2, product=0. No ADD, SHL or SHR issued. alu_control stays 000 with operands 0.
- op_a=op_b=0xFFFFFFFF (WIDTH=32): done at cycle 130, product=0xFFFFFFFE00000001. Exactly 32 ADD states observed.
- start pulsed at cycles 4 and 13 during an op_a=7, op_b=9 run: both ignored and the result is 63. A start in the first IDLE cycle after DONE is accepted and latches new operands.
- Reset during an op_a=0xFFFF, op_b=0xFFFF run:
  - rst_n=0 at cycle 20 with start=1: busy=0, done=0, product=0 on the next cycle, and no done pulse follows.
  - Then a new 6×7 run gives product=42.
- WIDTH=8, op_a=0xFF, op_b=0x80: done at cycle 2+24+1=27, product=0x7F80. count never exceeds 8.
